// File: rtl/dct2d_sched_pkg.sv
// rtl/dct2d_sched_pkg.sv - shared constants, row type, state enum and bus helpers (DRAIN state under DCT2D_SCHED_ROWOUT_EN)
package dct2d_sched_pkg;

    localparam int N     = 8;
    localparam int DCT_W = 32;

    typedef logic signed [N-1:0][DCT_W-1:0] row_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD,
        S_ROW,
        S_COL
`ifdef DCT2D_SCHED_ROWOUT_EN
        ,
        S_DRAIN
`endif
    } state_t;

    // Element j of the flat bus lives at bits [j*DCT_W +: DCT_W], which is
    // exactly the packed layout of row_t, so these are pure reinterpretations.
    function automatic row_t unpack_row(input logic [N*DCT_W-1:0] flat);
        return row_t'(flat);
    endfunction

    function automatic logic [N*DCT_W-1:0] pack_row(input row_t r);
        return r;
    endfunction

endpackage

// File: rtl/dct2d_sched_if.sv
// rtl/dct2d_sched_if.sv - block in/out and 1-D core handshake bundle
interface dct2d_sched_if #(
    parameter int IN_W = dct2d_sched_pkg::DCT_W
) ();
    import dct2d_sched_pkg::*;

    logic              blk_in_valid;
    logic              blk_in_ready;
    logic [N*IN_W-1:0] blk_in_row;

    logic              core_in_valid;
    logic              core_in_ready;
    logic [N*IN_W-1:0] core_in;

    logic              core_out_valid;
    logic              core_out_ready;
    logic [N*IN_W-1:0] core_out;

    logic              blk_out_valid;
    logic              blk_out_ready;
    logic [N*IN_W-1:0] blk_out_row;
    logic              blk_out_last;

    // Scheduler side
    modport master (
        input  blk_in_valid, blk_in_row, core_in_ready, core_out_valid, core_out, blk_out_ready,
        output blk_in_ready, core_in_valid, core_in, core_out_ready, blk_out_valid, blk_out_row,
               blk_out_last
    );

    // Fetch stage, 1-D core and quantiser side
    modport slave (
        output blk_in_valid, blk_in_row, core_in_ready, core_out_valid, core_out, blk_out_ready,
        input  blk_in_ready, core_in_valid, core_in, core_out_ready, blk_out_valid, blk_out_row,
               blk_out_last
    );

endinterface

// File: rtl/dct2d_tbuf.sv
// rtl/dct2d_tbuf.sv - 8x8 word buffer with row write and row-or-column read
module dct2d_tbuf
    import dct2d_sched_pkg::*;
#(
    parameter int IN_W = DCT_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [N*IN_W-1:0] wdata,
    input  logic [2:0]        raddr,
    input  logic              rd_col,
    output logic [N*IN_W-1:0] rdata
);

    logic [N-1:0][N-1:0][IN_W-1:0] mem_q;
    logic [N-1:0][N-1:0][IN_W-1:0] mem_d;

    // Row write; contents are don't-care after reset, so no reset term
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage register
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Read row raddr, or column raddr when rd_col (element i = mem[i][raddr])
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N; i++) begin
            rdata[i*IN_W +: IN_W] = rd_col ? mem_q[i][raddr] : mem_q[raddr][i];
        end
    end

endmodule

// File: rtl/dct2d_sched.sv
// rtl/dct2d_sched.sv - 2-D 8x8 DCT scheduler over a shared 1-D core (DCT2D_SCHED_ROWOUT_EN: buffered row-order output)
module dct2d_sched
    import dct2d_sched_pkg::*;
#(
    parameter int IN_W = DCT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    dct2d_sched_if.master bus,
    output logic          busy
);

    state_t     state_q, state_d;
    logic [3:0] ld_cnt_q, ld_cnt_d;
    logic [3:0] iss_cnt_q, iss_cnt_d;
    logic [3:0] ret_cnt_q, ret_cnt_d;

    logic              a_we;
    logic [2:0]        a_waddr;
    logic [N*IN_W-1:0] a_wdata;
    logic [N*IN_W-1:0] a_rdata;

    // A holds the input block, then is overwritten in place by the row pass
    dct2d_tbuf #(.IN_W(IN_W)) u_abuf (
        .clk    (clk),
        .we     (a_we),
        .waddr  (a_waddr),
        .wdata  (a_wdata),
        .raddr  (iss_cnt_q[2:0]),
        .rd_col (state_q == S_COL),
        .rdata  (a_rdata)
    );

`ifdef DCT2D_SCHED_ROWOUT_EN
    logic [3:0]        out_cnt_q, out_cnt_d;
    logic              o_we;
    logic [N*IN_W-1:0] o_rdata;

    // Column result c is stored as row c; reading column k gives output row k
    dct2d_tbuf #(.IN_W(IN_W)) u_obuf (
        .clk    (clk),
        .we     (o_we),
        .waddr  (ret_cnt_q[2:0]),
        .wdata  (bus.core_out),
        .raddr  (out_cnt_q[2:0]),
        .rd_col (1'b1),
        .rdata  (o_rdata)
    );
`endif

    // Next state, counters, buffer writes and all handshake outputs
    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        iss_cnt_d = iss_cnt_q;
        ret_cnt_d = ret_cnt_q;
        a_we      = 1'b0;
        a_waddr   = ld_cnt_q[2:0];
        a_wdata   = bus.blk_in_row;

        bus.blk_in_ready   = 1'b0;
        bus.core_in_valid  = 1'b0;
        bus.core_in        = a_rdata;
        bus.core_out_ready = 1'b0;
        bus.blk_out_valid  = 1'b0;
        bus.blk_out_last   = 1'b0;
`ifdef DCT2D_SCHED_ROWOUT_EN
        out_cnt_d       = out_cnt_q;
        o_we            = 1'b0;
        bus.blk_out_row = o_rdata;
`else
        bus.blk_out_row = bus.core_out;
`endif

        case (state_q)
            S_IDLE, S_LOAD: begin
                bus.blk_in_ready = 1'b1;
                if (bus.blk_in_valid) begin
                    a_we     = 1'b1;
                    ld_cnt_d = ld_cnt_q + 4'd1;
                    state_d  = S_LOAD;
                    if (ld_cnt_q == 4'd7) begin
                        state_d   = S_ROW;
                        ld_cnt_d  = 4'd0;
                        iss_cnt_d = 4'd0;
                        ret_cnt_d = 4'd0;
                    end
                end
            end

            S_ROW: begin
                bus.core_in_valid  = (iss_cnt_q < 4'd8);
                bus.core_out_ready = 1'b1;
                if ((iss_cnt_q < 4'd8) && bus.core_in_ready) begin
                    iss_cnt_d = iss_cnt_q + 4'd1;
                end
                // Results return in order and row ret_cnt was issued earlier,
                // so overwriting it in place never clobbers an unread row.
                a_waddr = ret_cnt_q[2:0];
                a_wdata = bus.core_out;
                if (bus.core_out_valid) begin
                    a_we      = 1'b1;
                    ret_cnt_d = ret_cnt_q + 4'd1;
                    if (ret_cnt_q == 4'd7) begin
                        state_d   = S_COL;
                        iss_cnt_d = 4'd0;
                        ret_cnt_d = 4'd0;
                    end
                end
            end

            S_COL: begin
                bus.core_in_valid = (iss_cnt_q < 4'd8);
                if ((iss_cnt_q < 4'd8) && bus.core_in_ready) begin
                    iss_cnt_d = iss_cnt_q + 4'd1;
                end
`ifdef DCT2D_SCHED_ROWOUT_EN
                bus.core_out_ready = 1'b1;
                if (bus.core_out_valid) begin
                    o_we      = 1'b1;
                    ret_cnt_d = ret_cnt_q + 4'd1;
                    if (ret_cnt_q == 4'd7) begin
                        state_d   = S_DRAIN;
                        iss_cnt_d = 4'd0;
                        ret_cnt_d = 4'd0;
                        out_cnt_d = 4'd0;
                    end
                end
`else
                // Column results flow straight out; downstream stalls the core
                bus.core_out_ready = bus.blk_out_ready;
                bus.blk_out_valid  = bus.core_out_valid;
                bus.blk_out_last   = (ret_cnt_q == 4'd7);
                if (bus.core_out_valid && bus.blk_out_ready) begin
                    ret_cnt_d = ret_cnt_q + 4'd1;
                    if (ret_cnt_q == 4'd7) begin
                        state_d   = S_IDLE;
                        iss_cnt_d = 4'd0;
                        ret_cnt_d = 4'd0;
                    end
                end
`endif
            end

`ifdef DCT2D_SCHED_ROWOUT_EN
            S_DRAIN: begin
                bus.blk_out_valid = (out_cnt_q < 4'd8);
                bus.blk_out_last  = (out_cnt_q == 4'd7);
                if ((out_cnt_q < 4'd8) && bus.blk_out_ready) begin
                    out_cnt_d = out_cnt_q + 4'd1;
                    if (out_cnt_q == 4'd7) begin
                        state_d   = S_IDLE;
                        out_cnt_d = 4'd0;
                    end
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers; reset aborts any block in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ld_cnt_q  <= 4'd0;
            iss_cnt_q <= 4'd0;
            ret_cnt_q <= 4'd0;
`ifdef DCT2D_SCHED_ROWOUT_EN
            out_cnt_q <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            ld_cnt_q  <= ld_cnt_d;
            iss_cnt_q <= iss_cnt_d;
            ret_cnt_q <= ret_cnt_d;
`ifdef DCT2D_SCHED_ROWOUT_EN
            out_cnt_q <= out_cnt_d;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_dct2d_sched.sv
// tb/tb_dct2d_sched.sv - self-checking bench for dct2d_sched with stub 1-D core (DCT2D_SCHED_ROWOUT_EN aware)
module tb_dct2d_sched;
    import dct2d_sched_pkg::*;

    localparam int  W  = 32;
    localparam real PI = 3.141592653589793;

    typedef struct {
        logic [8*W-1:0] d;
        int             due;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    dct2d_sched_if #(.IN_W(W)) bus ();

    dct2d_sched #(.IN_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic signed [W-1:0] xin [8][8];
    logic [8*W-1:0]      exp_q [$];
    logic [8*W-1:0]      got [8];
    int                  blk_beats = 0;

    int   lat = 1;
    bit   tog_mode = 0;
    bit   rnd_mode = 0;
    bit   use_dct = 0;
    int   n_iss = 0;
    int   cyc = 0;
    bit   tog = 0;
    ent_t stub_q [$];

    task automatic chk_bit(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0b required %0b", nm, act, req);
        end
    endtask

    task automatic chk_val(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, $signed(act), $signed(req));
        end
    endtask

    task automatic chk_row(input string nm, input logic [8*W-1:0] act, input logic [8*W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic chk_near(input string nm, input logic [W-1:0] act, input int req, input int tol);
        int d;
        d = $signed(act) - req;
        checks++;
        if (d > tol || d < -tol) begin
            errors++;
            $display("FAIL %s: got %0d required %0d +/- %0d", nm, $signed(act), req, tol);
        end
    endtask

    // Reference 1-D transform: identity, or orthonormal 8-point DCT-II rounded to nearest
    function automatic logic [8*W-1:0] core_fn(input logic [8*W-1:0] v, input bit dct);
        logic [8*W-1:0] r;
        real s;
        if (!dct) return v;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            s = 0.0;
            for (int n = 0; n < 8; n++) begin
                s += $itor($signed(v[n*W +: W])) * $cos(real'((2*n+1)*k) * PI / 16.0);
            end
            s = s * ((k == 0) ? $sqrt(0.125) : 0.5);
            r[k*W +: W] = $rtoi((s >= 0.0) ? s + 0.5 : s - 0.5);
        end
        return r;
    endfunction

    function automatic logic [8*W-1:0] row_of(input int i);
        logic [8*W-1:0] r;
        for (int j = 0; j < 8; j++) r[j*W +: W] = xin[i][j];
        return r;
    endfunction

    // Model: Y = colpass(rowpass(X)); emit columns of Y, or rows of Y when buffered
    task automatic build_expected(input bit dct);
        logic [8*W-1:0] r [8];
        logic [8*W-1:0] y [8];
        logic [8*W-1:0] v;
        for (int i = 0; i < 8; i++) r[i] = core_fn(row_of(i), dct);
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 8; i++) v[i*W +: W] = r[i][c*W +: W];
            y[c] = core_fn(v, dct);
        end
`ifdef DCT2D_SCHED_ROWOUT_EN
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 8; c++) v[c*W +: W] = y[c][k*W +: W];
            exp_q.push_back(v);
        end
`else
        for (int c = 0; c < 8; c++) exp_q.push_back(y[c]);
`endif
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) xin[i][j] = 8*i + j;
    endtask

    task automatic fill_signed();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) xin[i][j] = 100*i - 7*j*j - 50;
    endtask

    task automatic fill_const(input int val);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) xin[i][j] = val;
    endtask

    task automatic send_block();
        for (int i = 0; i < 8; i++) begin
            int n;
            bit acc;
            n   = 0;
            acc = 0;
            bus.blk_in_valid = 1'b1;
            bus.blk_in_row   = row_of(i);
            while (!acc && n < 500) begin
                @(negedge clk);
                acc = bus.blk_in_ready;
                @(posedge clk);
                #1;
                n++;
            end
            chk_bit("in_beat_accepted", acc, 1'b1);
        end
        bus.blk_in_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s timeout: %0d beats left, busy=%0b", nm, exp_q.size(), busy);
        end
        chk_val({nm, " beat_count"}, blk_beats, 8);
        blk_beats = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk_bit({tag, " blk_in_ready"},   bus.blk_in_ready,   1'b1);
        chk_bit({tag, " core_in_valid"},  bus.core_in_valid,  1'b0);
        chk_bit({tag, " core_out_ready"}, bus.core_out_ready, 1'b0);
        chk_bit({tag, " blk_out_valid"},  bus.blk_out_valid,  1'b0);
        chk_bit({tag, " blk_out_last"},   bus.blk_out_last,   1'b0);
        chk_bit({tag, " busy"},           busy,               1'b0);
    endtask

    // Handshakes seen mid-cycle, consumed by the stub after the next edge
    bit             s_in_hs, s_out_hs;
    logic [8*W-1:0] s_din;
    always @(negedge clk) begin
        s_in_hs  = bus.core_in_valid && bus.core_in_ready;
        s_out_hs = bus.core_out_valid && bus.core_out_ready;
        s_din    = bus.core_in;
    end

    // Stub 1-D core with fixed latency plus the downstream ready generator
    always @(posedge clk) begin
        ent_t e;
        #1;
        cyc++;
        tog = ~tog;
        if (!rst_n) begin
            stub_q.delete();
        end else begin
            if (s_out_hs && stub_q.size() > 0) void'(stub_q.pop_front());
            if (s_in_hs) begin
                e.d   = core_fn(s_din, use_dct);
                e.due = cyc + lat - 1;
                stub_q.push_back(e);
                n_iss++;
            end
        end
        bus.core_in_ready = tog_mode ? tog : 1'b1;
        if (stub_q.size() > 0 && stub_q[0].due <= cyc) begin
            bus.core_out_valid = 1'b1;
            bus.core_out       = stub_q[0].d;
        end else begin
            bus.core_out_valid = 1'b0;
            bus.core_out       = '0;
        end
        bus.blk_out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare process: output beats vs model, stall stability, outstanding bound
    int             beat_idx = 0;
    bit             out_pend = 0, cin_pend = 0;
    logic [8*W-1:0] held_out, held_cin, cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            beat_idx = 0;
            out_pend = 0;
            cin_pend = 0;
        end else begin
            if (out_pend) begin
                chk_bit("out_valid_held", bus.blk_out_valid, 1'b1);
                chk_row("out_row_held", bus.blk_out_row, held_out);
            end
            if (bus.blk_out_valid && bus.blk_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h required no beat", bus.blk_out_row);
                end else begin
                    cur = exp_q.pop_front();
                    chk_row("out_row", bus.blk_out_row, cur);
                end
                chk_bit("out_last", bus.blk_out_last, beat_idx == 7);
                got[beat_idx] = bus.blk_out_row;
                beat_idx      = (beat_idx + 1) % 8;
                blk_beats++;
                out_pend = 0;
            end else if (bus.blk_out_valid) begin
                out_pend = 1;
                held_out = bus.blk_out_row;
            end else begin
                out_pend = 0;
            end

            if (cin_pend) begin
                chk_bit("core_in_valid_held", bus.core_in_valid, 1'b1);
                chk_row("core_in_held", bus.core_in, held_cin);
            end
            if (bus.core_in_valid && bus.core_in_ready) begin
                chk_bit("outstanding_le_8", stub_q.size() < 8, 1'b1);
                cin_pend = 0;
            end else if (bus.core_in_valid) begin
                cin_pend = 1;
                held_cin = bus.core_in;
            end else begin
                cin_pend = 0;
            end
        end
    end

    initial begin
        int n;
        int base;
        bus.blk_in_valid = 1'b0;
        bus.blk_in_row   = '0;

        repeat (3) @(posedge clk);
        #2;
        check_reset("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Identity core, latency 1, ramp 8i+j
        fill_ramp();
        build_expected(0);
        send_block();
        wait_done("ramp_lat1");
`ifdef DCT2D_SCHED_ROWOUT_EN
        chk_val("lit_r3_e2", got[3][2*W +: W], 32'd26);
        chk_val("lit_r0_e1", got[0][1*W +: W], 32'd1);
        chk_val("lit_r7_e7", got[7][7*W +: W], 32'd63);
`else
        chk_val("lit_b3_e2", got[3][2*W +: W], 32'd19);
        chk_val("lit_b0_e1", got[0][1*W +: W], 32'd8);
        chk_val("lit_b7_e7", got[7][7*W +: W], 32'd63);
`endif

        // Latency 5 with core_in_ready toggling every cycle
        lat      = 5;
        tog_mode = 1;
        build_expected(0);
        send_block();
        wait_done("ramp_lat5_toggle");
`ifdef DCT2D_SCHED_ROWOUT_EN
        chk_val("lit2_r5_e4", got[5][4*W +: W], 32'd44);
`else
        chk_val("lit2_b5_e4", got[5][4*W +: W], 32'd37);
`endif

        // Random downstream backpressure, signed data
        lat      = 2;
        tog_mode = 0;
        rnd_mode = 1;
        fill_signed();
        build_expected(0);
        send_block();
        wait_done("signed_backpressure");
        chk_val("lit3_e00", got[0][0 +: W], -32'sd50);
        rnd_mode = 0;

        // Reset during the column pass, then a clean block
        lat = 1;
        fill_ramp();
        build_expected(0);
        base = n_iss;
        send_block();
        n = 0;
        while (n_iss < base + 10 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk_bit("reached_col", n_iss >= base + 10, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("midcol");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2;
        rst_n     = 1'b1;
        blk_beats = 0;
        fill_signed();
        build_expected(0);
        send_block();
        wait_done("after_reset");

        // Real DCT core, flat block of 100<<15
        use_dct = 1;
        lat     = 2;
        fill_const(100 << 15);
        build_expected(1);
        send_block();
        wait_done("dct_flat");
        for (int b = 0; b < 8; b++)
            for (int e = 0; e < 8; e++)
                chk_near("dct_coef", got[b][e*W +: W], (b == 0 && e == 0) ? (800 << 15) : 0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
